x4_spi_arbiter: RTL and testbench
=================================

X4_SPI_ARBITER -- requirements
Module: x4_spi_arbiter

Interface
- REQ-001: The block SHALL use one clock and a synchronous, active-high reset.
- REQ-002: Parameter TIMEOUT_CYCLES, default 4096: idle-owner cycles before a forced release.
- REQ-003: Parameter GAP_CYCLES, default 2: cycles spi_cs is held high between owners.
- REQ-004: clk  in  1  system clock (clk_100m domain); all ports synchronous to it.
- REQ-005: rst  in  1  synchronous active-high reset.
- REQ-006: x4_init_done  in  1  MCU requester eligible only when 1.
- REQ-007: req_fpga, req_mcu  in  1 each  bus request, held for the whole burst.
- REQ-008: gnt_fpga, gnt_mcu  out  1 each  bus ownership.
- REQ-009: fpga_cs, fpga_tx_en, fpga_rx_en  in  1 each; fpga_data_in  in  8  FPGA-side SPI command.
- REQ-010: mcu_cs, mcu_tx_en, mcu_rx_en  in  1 each; mcu_data_in  in  8  MCU-side SPI command.
- REQ-011: spi_cs, spi_tx_en, spi_rx_en  out  1 each; spi_data_in  out  8  to spi_module.
- REQ-012: spi_tx_done, spi_rx_done  in  1 each  completion pulses from spi_module.
- REQ-013: fpga_tx_done, fpga_rx_done, mcu_tx_done, mcu_rx_done  out  1 each  routed completions.
- REQ-014: busy  out  1  high in any non-IDLE state.
- REQ-015: timeout  out  1  one-cycle pulse on forced release.

Function
- REQ-016: FSM states SHALL be IDLE, OWN_FPGA, OWN_MCU, DRAIN and GAP.
- REQ-017: IDLE -> OWN_FPGA on req_fpga; IDLE -> OWN_MCU on req_mcu & x4_init_done.
- REQ-018: Simultaneous eligible requests SHALL go round-robin to the requester not served last.
- REQ-019: Grant SHALL be registered: gnt_x rises the cycle after the IDLE decision and stays high through OWN_x and DRAIN.
- REQ-020: In OWN_x, the owner's cs/tx_en/rx_en/data_in SHALL pass combinationally to spi_*; the non-owner's inputs SHALL be ignored.
- REQ-021: When unowned (IDLE, GAP), outputs SHALL be spi_cs=1, spi_tx_en=0, spi_rx_en=0, spi_data_in=0.
- REQ-022: A byte SHALL be in flight from a tx_en/rx_en pass-through until the matching spi_*_done.
- REQ-023: spi_tx_done/spi_rx_done SHALL route only to the current owner's *_done outputs, the same cycle.
- REQ-024: Owner dropping req with no byte in flight SHALL go OWN_x -> GAP.
- REQ-025: Owner dropping req with a byte in flight SHALL go OWN_x -> DRAIN, forwarding tx_en/rx_en as 0 and cs as 1 once that byte's done arrives, then DRAIN -> GAP.
- REQ-026: gnt SHALL fall on entry to GAP.
- REQ-027: GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; requests are not sampled during GAP.
- REQ-028: x4_init_done falling while in OWN_MCU SHALL be treated as a req_mcu drop.
- REQ-029: A done pulse arriving with no owner SHALL be discarded.

Reset
- REQ-030: On rst, the FSM SHALL enter IDLE the next cycle, including mid-byte.
- REQ-031: Reset values: gnt_*=0, spi_cs=1, spi_tx_en=0, spi_rx_en=0, spi_data_in=0, busy=0, timeout=0, all *_done=0.
- REQ-032: On rst, the last-served pointer SHALL be MCU, so the FPGA wins the first tie; the timeout counter SHALL be 0.

Configuration
- REQ-033: With X4_ARB_TIMEOUT_EN defined, a counter SHALL count OWN_x cycles with no tx_en, rx_en or done activity, clearing on any activity.
- REQ-034: When that counter reaches TIMEOUT_CYCLES, the block SHALL pulse timeout and move OWN_x -> GAP.
- REQ-035: After a forced release, the timed-out requester SHALL be ineligible until its req has been observed low.
- REQ-036: Without X4_ARB_TIMEOUT_EN, the counter SHALL be absent, timeout SHALL be tied 0, and ownership SHALL end only by req drop.

Structure
- REQ-037: Shared package x4_pkg SHALL hold the FSM state encoding, owner encoding (OWNER_FPGA, OWNER_MCU) and default constants TIMEOUT_CYCLES and GAP_CYCLES.
- REQ-038: The idle counter SHALL be sub-module x4_arb_timer, instantiated only under X4_ARB_TIMEOUT_EN.

Verification
- REQ-039: req_fpga=1 with x4_init_done=0 and req_mcu=1 -> gnt_fpga=1 one cycle later; gnt_mcu stays 0 throughout.
- REQ-040: Both req held, x4_init_done=1, each dropping after 1 byte -> grants FPGA, MCU, FPGA, each separated by 2 cycles of spi_cs=1.
- REQ-041: MCU owner sends mcu_data_in=8'hA5 with tx_en while FPGA drives 8'h3C -> spi_data_in=8'hA5; spi_tx_done appears only on mcu_tx_done.
- REQ-042: req_mcu dropped 3 cycles before spi_rx_done -> state DRAIN, gnt_mcu held until done, then GAP.
- REQ-043: X4_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and an idle owner -> timeout pulse at cycle 16; no re-grant until req toggles low.
- REQ-044: rst asserted mid-byte -> next cycle spi_cs=1, gnt_*=0, busy=0.

Source files
------------

// File: rtl/x4_pkg.sv
// Shared definitions for the x4 SPI arbiter: FSM state encoding, owner
// encoding and the default timing constants.
package x4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_OWN_FPGA = 3'd1,
      ST_OWN_MCU  = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_GAP      = 3'd4
   } arb_state_e;

   typedef enum logic {
      OWNER_FPGA = 1'b0,
      OWNER_MCU  = 1'b1
   } owner_e;

   // Idle-owner cycles before a forced release (timeout build only).
   localparam int TIMEOUT_CYCLES = 4096;
   // Cycles the shared chip select is held high between owners.
   localparam int GAP_CYCLES     = 2;

endpackage

// File: rtl/x4_arb_timer.sv
// Idle-owner watchdog for the x4 SPI arbiter. Counts consecutive owned
// cycles with no enable or completion activity and flags expiry on the
// TIMEOUT_CYCLES-th such cycle. Only instantiated when X4_ARB_TIMEOUT_EN
// is defined.
module x4_arb_timer #(
   parameter int TIMEOUT_CYCLES = x4_pkg::TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic activity_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Expiry fires combinationally on the last idle cycle so the FSM can
   // release the bus at the same clock edge.
   assign expired_o = run_i && !activity_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Next count: restart whenever the bus is not owned, on any activity,
   // or once expiry has been reported.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run_i || activity_i || expired_o) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/x4_spi_arbiter.sv
// Two-master (FPGA / MCU) arbiter in front of a single spi_module.
// Grants are registered, the owner's SPI command is passed through
// combinationally, completions are routed back to the owner only, and a
// fixed chip-select gap separates consecutive owners. A byte that is in
// flight when the owner lets go is drained before the bus is released.
// Optional feature: define X4_ARB_TIMEOUT_EN to add the idle-owner
// watchdog (x4_arb_timer) that forces a release and pulses timeout.
module x4_spi_arbiter #(
   parameter int TIMEOUT_CYCLES = x4_pkg::TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = x4_pkg::GAP_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       x4_init_done,
   input  logic       req_fpga,
   input  logic       req_mcu,
   output logic       gnt_fpga,
   output logic       gnt_mcu,
   input  logic       fpga_cs,
   input  logic       fpga_tx_en,
   input  logic       fpga_rx_en,
   input  logic [7:0] fpga_data_in,
   input  logic       mcu_cs,
   input  logic       mcu_tx_en,
   input  logic       mcu_rx_en,
   input  logic [7:0] mcu_data_in,
   output logic       spi_cs,
   output logic       spi_tx_en,
   output logic       spi_rx_en,
   output logic [7:0] spi_data_in,
   input  logic       spi_tx_done,
   input  logic       spi_rx_done,
   output logic       fpga_tx_done,
   output logic       fpga_rx_done,
   output logic       mcu_tx_done,
   output logic       mcu_rx_done,
   output logic       busy,
   output logic       timeout
);

   import x4_pkg::*;

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   arb_state_e    state_q;
   owner_e        owner_q;
   owner_e        last_q;
   logic          gnt_fpga_q;
   logic          gnt_mcu_q;
   logic          timeout_q;
   logic          pend_tx_q;
   logic          pend_rx_q;
   logic [GW-1:0] gap_cnt_q;

   logic       own_cs;
   logic       own_tx_en;
   logic       own_rx_en;
   logic [7:0] own_data;
   logic       own_active;
   logic       owned;
   logic       pend_tx_d;
   logic       pend_rx_d;
   logic       in_flight_d;
   logic       owner_drop;
   logic       fpga_elig;
   logic       mcu_elig;
   logic       pick_fpga;
   logic       pick_mcu;
   logic       tmo_expired;

   // The current owner's command, selected once so the datapath and the
   // in-flight tracking agree on what is being forwarded.
   assign own_cs     = (owner_q == OWNER_MCU) ? mcu_cs      : fpga_cs;
   assign own_tx_en  = (owner_q == OWNER_MCU) ? mcu_tx_en   : fpga_tx_en;
   assign own_rx_en  = (owner_q == OWNER_MCU) ? mcu_rx_en   : fpga_rx_en;
   assign own_data   = (owner_q == OWNER_MCU) ? mcu_data_in : fpga_data_in;

   assign own_active = (state_q == ST_OWN_FPGA) || (state_q == ST_OWN_MCU);
   assign owned      = own_active || (state_q == ST_DRAIN);

   // A byte is in flight from the forwarded enable until its matching
   // done; a new start in the same cycle as a done keeps it pending.
   assign pend_tx_d   = (pend_tx_q && !spi_tx_done) || (own_active && own_tx_en);
   assign pend_rx_d   = (pend_rx_q && !spi_rx_done) || (own_active && own_rx_en);
   assign in_flight_d = pend_tx_d || pend_rx_d;

   // Losing x4_init_done while the MCU owns the bus counts as a release.
   assign owner_drop = ((state_q == ST_OWN_FPGA) && !req_fpga) ||
                       ((state_q == ST_OWN_MCU) && (!req_mcu || !x4_init_done));

`ifdef X4_ARB_TIMEOUT_EN
   logic fpga_block_q;
   logic mcu_block_q;
   logic activity;

   assign activity = own_tx_en || own_rx_en || spi_tx_done || spi_rx_done;

   x4_arb_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run_i     (own_active),
      .activity_i(activity),
      .expired_o (tmo_expired)
   );

   // A timed-out requester stays locked out until its req is seen low.
   always_ff @(posedge clk) begin
      if (rst) begin
         fpga_block_q <= 1'b0;
         mcu_block_q  <= 1'b0;
      end else begin
         if (tmo_expired && (state_q == ST_OWN_FPGA)) begin
            fpga_block_q <= 1'b1;
         end else if (!req_fpga) begin
            fpga_block_q <= 1'b0;
         end
         if (tmo_expired && (state_q == ST_OWN_MCU)) begin
            mcu_block_q <= 1'b1;
         end else if (!req_mcu) begin
            mcu_block_q <= 1'b0;
         end
      end
   end

   assign fpga_elig = req_fpga && !fpga_block_q;
   assign mcu_elig  = req_mcu && x4_init_done && !mcu_block_q;
`else
   assign tmo_expired = 1'b0;
   assign fpga_elig   = req_fpga;
   assign mcu_elig    = req_mcu && x4_init_done;
`endif

   // Round-robin tie break: on a tie the requester not served last wins.
   assign pick_mcu  = mcu_elig && (!fpga_elig || (last_q == OWNER_FPGA));
   assign pick_fpga = fpga_elig && !pick_mcu;

   // Arbitration FSM with registered grants and timeout pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_FPGA;
         last_q     <= OWNER_MCU;
         gnt_fpga_q <= 1'b0;
         gnt_mcu_q  <= 1'b0;
         timeout_q  <= 1'b0;
         pend_tx_q  <= 1'b0;
         pend_rx_q  <= 1'b0;
         gap_cnt_q  <= '0;
      end else begin
         timeout_q <= 1'b0;
         pend_tx_q <= pend_tx_d;
         pend_rx_q <= pend_rx_d;
         case (state_q)
            ST_IDLE: begin
               if (pick_fpga) begin
                  state_q    <= ST_OWN_FPGA;
                  owner_q    <= OWNER_FPGA;
                  last_q     <= OWNER_FPGA;
                  gnt_fpga_q <= 1'b1;
               end else if (pick_mcu) begin
                  state_q   <= ST_OWN_MCU;
                  owner_q   <= OWNER_MCU;
                  last_q    <= OWNER_MCU;
                  gnt_mcu_q <= 1'b1;
               end
            end
            ST_OWN_FPGA, ST_OWN_MCU: begin
               if (tmo_expired) begin
                  state_q    <= ST_GAP;
                  gnt_fpga_q <= 1'b0;
                  gnt_mcu_q  <= 1'b0;
                  timeout_q  <= 1'b1;
                  pend_tx_q  <= 1'b0;
                  pend_rx_q  <= 1'b0;
                  gap_cnt_q  <= GAP_LOAD;
               end else if (owner_drop) begin
                  if (in_flight_d) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q    <= ST_GAP;
                     gnt_fpga_q <= 1'b0;
                     gnt_mcu_q  <= 1'b0;
                     gap_cnt_q  <= GAP_LOAD;
                  end
               end
            end
            ST_DRAIN: begin
               if (!in_flight_d) begin
                  state_q    <= ST_GAP;
                  gnt_fpga_q <= 1'b0;
                  gnt_mcu_q  <= 1'b0;
                  gap_cnt_q  <= GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               gnt_fpga_q <= 1'b0;
               gnt_mcu_q  <= 1'b0;
            end
         endcase
      end
   end

   // SPI mux and completion routing: pass-through while owned, enables
   // suppressed while draining, bus parked and dones dropped otherwise.
   always_comb begin
      spi_cs       = 1'b1;
      spi_tx_en    = 1'b0;
      spi_rx_en    = 1'b0;
      spi_data_in  = 8'h00;
      fpga_tx_done = 1'b0;
      fpga_rx_done = 1'b0;
      mcu_tx_done  = 1'b0;
      mcu_rx_done  = 1'b0;
      if (own_active) begin
         spi_cs      = own_cs;
         spi_tx_en   = own_tx_en;
         spi_rx_en   = own_rx_en;
         spi_data_in = own_data;
      end else if (state_q == ST_DRAIN) begin
         spi_cs      = own_cs;
         spi_data_in = own_data;
      end
      if (owned) begin
         if (owner_q == OWNER_MCU) begin
            mcu_tx_done = spi_tx_done;
            mcu_rx_done = spi_rx_done;
         end else begin
            fpga_tx_done = spi_tx_done;
            fpga_rx_done = spi_rx_done;
         end
      end
   end

   assign gnt_fpga = gnt_fpga_q;
   assign gnt_mcu  = gnt_mcu_q;
   assign busy     = (state_q != ST_IDLE);
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_x4_spi_arbiter.sv
// Directed bench for x4_spi_arbiter: a vector table for the owned-bus
// datapath and completion routing, plus hand-written sequences for
// eligibility, round robin, drain, reset mid-byte and the timeout option.
`timescale 1ns/1ps
module tb_x4_spi_arbiter;

   localparam int TB_GAP = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       x4_init_done;
   logic       req_fpga, req_mcu;
   logic       gnt_fpga, gnt_mcu;
   logic       fpga_cs, fpga_tx_en, fpga_rx_en;
   logic [7:0] fpga_data_in;
   logic       mcu_cs, mcu_tx_en, mcu_rx_en;
   logic [7:0] mcu_data_in;
   logic       spi_cs, spi_tx_en, spi_rx_en;
   logic [7:0] spi_data_in;
   logic       spi_tx_done, spi_rx_done;
   logic       fpga_tx_done, fpga_rx_done, mcu_tx_done, mcu_rx_done;
   logic       busy, timeout;

   int checks = 0;
   int errors = 0;

   x4_spi_arbiter #(
      .TIMEOUT_CYCLES(16),
      .GAP_CYCLES    (TB_GAP)
   ) dut (
      .clk(clk), .rst(rst), .x4_init_done(x4_init_done),
      .req_fpga(req_fpga), .req_mcu(req_mcu),
      .gnt_fpga(gnt_fpga), .gnt_mcu(gnt_mcu),
      .fpga_cs(fpga_cs), .fpga_tx_en(fpga_tx_en), .fpga_rx_en(fpga_rx_en),
      .fpga_data_in(fpga_data_in),
      .mcu_cs(mcu_cs), .mcu_tx_en(mcu_tx_en), .mcu_rx_en(mcu_rx_en),
      .mcu_data_in(mcu_data_in),
      .spi_cs(spi_cs), .spi_tx_en(spi_tx_en), .spi_rx_en(spi_rx_en),
      .spi_data_in(spi_data_in),
      .spi_tx_done(spi_tx_done), .spi_rx_done(spi_rx_done),
      .fpga_tx_done(fpga_tx_done), .fpga_rx_done(fpga_rx_done),
      .mcu_tx_done(mcu_tx_done), .mcu_rx_done(mcu_rx_done),
      .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       own_mcu;
      logic [2:0] f_ctl;   // {cs, tx_en, rx_en}
      logic [7:0] f_data;
      logic [2:0] m_ctl;
      logic [7:0] m_data;
      logic [1:0] sd;      // {spi_tx_done, spi_rx_done}
      logic [2:0] e_ctl;   // expected {spi_cs, spi_tx_en, spi_rx_en}
      logic [7:0] e_data;
      logic [3:0] e_done;  // expected {fpga_tx, fpga_rx, mcu_tx, mcu_rx}
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mkv(input logic own, input logic [2:0] fc, input logic [7:0] fd,
                                input logic [2:0] mc, input logic [7:0] md, input logic [1:0] sd,
                                input logic [2:0] ec, input logic [7:0] ed, input logic [3:0] edn);
      vec_t v;
      v.own_mcu = own; v.f_ctl = fc; v.f_data = fd; v.m_ctl = mc; v.m_data = md;
      v.sd = sd; v.e_ctl = ec; v.e_data = ed; v.e_done = edn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_fpga = 1'b0; req_mcu = 1'b0; x4_init_done = 1'b1;
      fpga_cs = 1'b1; fpga_tx_en = 1'b0; fpga_rx_en = 1'b0; fpga_data_in = 8'h00;
      mcu_cs = 1'b1; mcu_tx_en = 1'b0; mcu_rx_en = 1'b0; mcu_data_in = 8'h00;
      spi_tx_done = 1'b0; spi_rx_done = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic acquire(input logic mcu);
      int n = 0;
      req_fpga = !mcu; req_mcu = mcu; x4_init_done = 1'b1;
      while (!(mcu ? gnt_mcu : gnt_fpga) && n < 20) begin
         step();
         n++;
      end
      chk(mcu ? "acquire_mcu" : "acquire_fpga", {31'd0, (mcu ? gnt_mcu : gnt_fpga)}, 32'd1);
   endtask

   task automatic release_bus();
      int n = 0;
      clear_inputs();
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk("release_idle", {31'd0, busy}, 32'd0);
   endtask

   // One byte by the current owner, then a release; returns the number of
   // cycles with both grants low and how many of those had spi_cs high.
   task automatic burst(input logic mcu, output int low_cnt, output int cs_hi_cnt);
      low_cnt = 0; cs_hi_cnt = 0;
      if (mcu) begin mcu_cs = 1'b0; mcu_tx_en = 1'b1; end
      else     begin fpga_cs = 1'b0; fpga_tx_en = 1'b1; end
      step();
      mcu_tx_en = 1'b0; fpga_tx_en = 1'b0; spi_tx_done = 1'b1;
      #1;
      chk("rr_done_route", {30'd0, fpga_tx_done, mcu_tx_done}, mcu ? 32'd1 : 32'd2);
      step();
      spi_tx_done = 1'b0;
      if (mcu) begin req_mcu = 1'b0; mcu_cs = 1'b1; end
      else     begin req_fpga = 1'b0; fpga_cs = 1'b1; end
      step();
      req_fpga = 1'b1; req_mcu = 1'b1;
      while (!gnt_fpga && !gnt_mcu && low_cnt < 20) begin
         if (spi_cs) cs_hi_cnt++;
         step();
         low_cnt++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [2:0] rr_exp;
      logic       prev_own;
      int         low_cnt, cs_hi_cnt, n, hits;

      vecs[0] = mkv(1'b0, 3'b010, 8'h3C, 3'b010, 8'hA5, 2'b00, 3'b010, 8'h3C, 4'b0000);
      vecs[1] = mkv(1'b0, 3'b001, 8'h81, 3'b001, 8'hA5, 2'b10, 3'b001, 8'h81, 4'b1000);
      vecs[2] = mkv(1'b0, 3'b000, 8'h81, 3'b011, 8'h77, 2'b01, 3'b000, 8'h81, 4'b0100);
      vecs[3] = mkv(1'b0, 3'b100, 8'h00, 3'b010, 8'h99, 2'b00, 3'b100, 8'h00, 4'b0000);
      vecs[4] = mkv(1'b1, 3'b010, 8'h3C, 3'b010, 8'hA5, 2'b00, 3'b010, 8'hA5, 4'b0000);
      vecs[5] = mkv(1'b1, 3'b010, 8'h3C, 3'b000, 8'hA5, 2'b10, 3'b000, 8'hA5, 4'b0010);
      vecs[6] = mkv(1'b1, 3'b101, 8'h3C, 3'b001, 8'h5A, 2'b00, 3'b001, 8'h5A, 4'b0000);
      vecs[7] = mkv(1'b1, 3'b011, 8'hFF, 3'b100, 8'h00, 2'b01, 3'b100, 8'h00, 4'b0001);

      // Reset values, and a done pulse with no owner is dropped.
      do_reset();
      chk("rst_gnt", {30'd0, gnt_fpga, gnt_mcu}, 32'd0);
      chk("rst_spi", {21'd0, spi_cs, spi_tx_en, spi_rx_en, spi_data_in}, {21'd0, 3'b100, 8'h00});
      chk("rst_busy_tmo", {30'd0, busy, timeout}, 32'd0);
      spi_tx_done = 1'b1; spi_rx_done = 1'b1;
      #1;
      chk("idle_done_discard", {28'd0, fpga_tx_done, fpga_rx_done, mcu_tx_done, mcu_rx_done}, 32'd0);
      spi_tx_done = 1'b0; spi_rx_done = 1'b0;
      step();

      // Owned-bus datapath and completion routing table.
      prev_own = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            acquire(vecs[i].own_mcu);
         end else if (vecs[i].own_mcu != prev_own) begin
            release_bus();
            acquire(vecs[i].own_mcu);
         end
         prev_own = vecs[i].own_mcu;
         {fpga_cs, fpga_tx_en, fpga_rx_en} = vecs[i].f_ctl;
         fpga_data_in = vecs[i].f_data;
         {mcu_cs, mcu_tx_en, mcu_rx_en} = vecs[i].m_ctl;
         mcu_data_in = vecs[i].m_data;
         {spi_tx_done, spi_rx_done} = vecs[i].sd;
         #1;
         $display("vec %0d own_mcu=%0d spi_cs=%b tx=%b rx=%b data=%h done=%b%b%b%b", i,
                  vecs[i].own_mcu, spi_cs, spi_tx_en, spi_rx_en, spi_data_in,
                  fpga_tx_done, fpga_rx_done, mcu_tx_done, mcu_rx_done);
         chk("vec_ctl", {29'd0, spi_cs, spi_tx_en, spi_rx_en}, {29'd0, vecs[i].e_ctl});
         chk("vec_data", {24'd0, spi_data_in}, {24'd0, vecs[i].e_data});
         chk("vec_done", {28'd0, fpga_tx_done, fpga_rx_done, mcu_tx_done, mcu_rx_done},
             {28'd0, vecs[i].e_done});
         step();
      end
      release_bus();

      // MCU ineligible without x4_init_done: FPGA wins, MCU never granted.
      x4_init_done = 1'b0; req_fpga = 1'b1; req_mcu = 1'b1;
      #1;
      chk("elig_pre_edge", {31'd0, gnt_fpga}, 32'd0);
      step();
      chk("elig_gnt_fpga", {31'd0, gnt_fpga}, 32'd1);
      hits = gnt_mcu ? 1 : 0;
      req_fpga = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (gnt_mcu) hits++;
      end
      $display("eligibility: gnt_mcu seen %0d times, busy=%b", hits, busy);
      chk("elig_no_mcu", hits, 32'd0);
      chk("elig_idle", {31'd0, busy}, 32'd0);

      // Round robin from reset: FPGA, MCU, FPGA. Between owners the grants
      // stay low for the GAP window plus the IDLE arbitration cycle.
      do_reset();
      rr_exp = 3'b010;
      req_fpga = 1'b1; req_mcu = 1'b1; x4_init_done = 1'b1;
      for (int g = 0; g < 3; g++) begin
         n = 0;
         while (!gnt_fpga && !gnt_mcu && n < 20) begin
            step();
            n++;
         end
         $display("rr grant %0d: gnt_fpga=%b gnt_mcu=%b", g, gnt_fpga, gnt_mcu);
         chk("rr_any_grant", {31'd0, gnt_fpga | gnt_mcu}, 32'd1);
         chk("rr_owner", {31'd0, gnt_mcu}, {31'd0, rr_exp[g]});
         chk("rr_exclusive", {31'd0, gnt_fpga & gnt_mcu}, 32'd0);
         if (g < 2) begin
            burst(gnt_mcu, low_cnt, cs_hi_cnt);
            chk("rr_gap_len", low_cnt, TB_GAP + 1);
            chk("rr_gap_cs", cs_hi_cnt, TB_GAP + 1);
         end
      end
      release_bus();

      // Drain: MCU drops req 3 cycles before spi_rx_done.
      acquire(1'b1);
      mcu_cs = 1'b0; mcu_rx_en = 1'b1; mcu_data_in = 8'h42;
      step();
      mcu_rx_en = 1'b0;
      step();
      req_mcu = 1'b0;
      step();
      mcu_rx_en = 1'b1;
      #1;
      $display("drain d1: gnt_mcu=%b busy=%b spi_rx_en=%b", gnt_mcu, busy, spi_rx_en);
      chk("drain_gnt_d1", {30'd0, gnt_mcu, busy}, 32'd3);
      chk("drain_rx_blocked", {31'd0, spi_rx_en}, 32'd0);
      mcu_rx_en = 1'b0;
      step();
      chk("drain_gnt_d2", {31'd0, gnt_mcu}, 32'd1);
      step();
      spi_rx_done = 1'b1;
      #1;
      chk("drain_done_route", {28'd0, fpga_tx_done, fpga_rx_done, mcu_tx_done, mcu_rx_done}, 32'd1);
      chk("drain_gnt_d3", {31'd0, gnt_mcu}, 32'd1);
      step();
      spi_rx_done = 1'b0;
      $display("drain exit: gnt_mcu=%b spi_cs=%b busy=%b", gnt_mcu, spi_cs, busy);
      chk("drain_gap", {29'd0, gnt_mcu, spi_cs, busy}, 32'd3);
      release_bus();

      // Reset in the middle of a byte.
      acquire(1'b0);
      fpga_cs = 1'b0; fpga_tx_en = 1'b1; fpga_data_in = 8'hC3;
      #1;
      chk("midbyte_pass", {31'd0, spi_tx_en}, 32'd1);
      rst = 1'b1;
      step();
      $display("reset mid-byte: spi_cs=%b gnt=%b%b busy=%b", spi_cs, gnt_fpga, gnt_mcu, busy);
      chk("midbyte_rst", {28'd0, spi_cs, gnt_fpga, gnt_mcu, busy}, 32'd8);
      rst = 1'b0;
      clear_inputs();
      step();

`ifdef X4_ARB_TIMEOUT_EN
      // Idle owner is released after 16 idle cycles, then locked out.
      do_reset();
      acquire(1'b0);
      n = 0; hits = 0;
      while (gnt_fpga && n < 100) begin
         if (timeout) hits++;
         step();
         n++;
      end
      $display("timeout: owned %0d cycles, timeout=%b", n, timeout);
      chk("tmo_len", n, 32'd16);
      chk("tmo_early", hits, 32'd0);
      chk("tmo_pulse", {31'd0, timeout}, 32'd1);
      step();
      chk("tmo_pulse_end", {31'd0, timeout}, 32'd0);
      hits = 0;
      for (int c = 0; c < 20; c++) begin
         if (gnt_fpga) hits++;
         step();
      end
      chk("tmo_lockout", hits, 32'd0);
      req_fpga = 1'b0;
      step();
      req_fpga = 1'b1;
      n = 0;
      while (!gnt_fpga && n < 20) begin
         step();
         n++;
      end
      chk("tmo_regrant", {31'd0, gnt_fpga}, 32'd1);
      release_bus();
`else
      // Without the watchdog an idle owner keeps the bus indefinitely.
      do_reset();
      acquire(1'b0);
      hits = 0;
      for (int c = 0; c < 40; c++) begin
         if (timeout) hits++;
         step();
      end
      $display("no-timeout build: gnt_fpga=%b timeout pulses=%0d", gnt_fpga, hits);
      chk("notmo_hold", {31'd0, gnt_fpga}, 32'd1);
      chk("notmo_pulse", hits, 32'd0);
      release_bus();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
